game_state_controller: RTL

GAME_STATE_CONTROLLER -- requirements
Module: game_state_controller

---
 rtl/game_state_controller_if.sv | 29 ++
 rtl/game_state_controller.sv | 130 +++++++++++++
 2 files changed

// File: rtl/game_state_controller_if.sv
// Game controller bus: frame/player events in, game state and status out.
// Latency: none here; this file only bundles the signals.
// Backpressure: none; every signal is a level or a one-clk pulse.
interface game_state_controller_if;
  logic        tick;
  logic        start_btn;
  logic        pacman_is_dead;
  logic        pellet_eaten;
  logic        logic_rst;
  logic        freeze;
  logic [2:0]  state;
  logic [1:0]  lives;
  logic [15:0] score;
  logic [8:0]  pellets_left;
  logic        game_over;
  logic        game_won;

  // Game logic / bench side: drives the events and observes the status.
  modport master (
    output tick, start_btn, pacman_is_dead, pellet_eaten,
    input  logic_rst, freeze, state, lives, score, pellets_left, game_over, game_won
  );

  // Controller side.
  modport slave (
    input  tick, start_btn, pacman_is_dead, pellet_eaten,
    output logic_rst, freeze, state, lives, score, pellets_left, game_over, game_won
  );
endinterface

// File: rtl/game_state_controller.sv
// Game flow FSM: IDLE/READY/PLAY/DYING/OVER/WON with lives, score and pellet bookkeeping.
// Latency: every qualifying input changes the registered outputs exactly one clk later.
// Backpressure: none; inputs that the current state does not use are ignored.
module game_state_controller #(
  parameter int LIVES_INIT    = 3,
  parameter int READY_FRAMES  = 120,
  parameter int DEATH_FRAMES  = 60,
  parameter int PELLET_COUNT  = 240,
  parameter int PELLET_POINTS = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  game_state_controller_if.slave  gs
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_DYING = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;
  localparam logic [2:0] S_WON   = 3'd5;

  localparam logic [1:0]  LIVES_LD  = 2'(LIVES_INIT);
  localparam logic [7:0]  READY_LD  = 8'(READY_FRAMES);
  localparam logic [7:0]  DEATH_LD  = 8'(DEATH_FRAMES);
  localparam logic [8:0]  PELLET_LD = 9'(PELLET_COUNT);
  localparam logic [16:0] POINTS_17 = 17'(PELLET_POINTS);

  logic [2:0]  state_q, state_d;
  logic [1:0]  lives_q, lives_d;
  logic [15:0] score_q, score_d;
  logic [8:0]  pellets_q, pellets_d;
  logic [7:0]  timer_q, timer_d;
  logic        logic_rst_q, freeze_q, over_q, won_q;
  logic [16:0] score_sum;

  // Score plus one pellet, wide by one bit so the carry flags saturation.
  assign score_sum = {1'b0, score_q} + POINTS_17;

  // Next-state and bookkeeping for the game flow.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    score_d   = score_q;
    pellets_d = pellets_q;
    timer_d   = timer_q;
    case (state_q)
      S_IDLE, S_OVER, S_WON: begin
        // A start also wins over a same-clk tick: the timer loads unmodified.
        if (gs.start_btn) begin
          state_d   = S_READY;
          lives_d   = LIVES_LD;
          score_d   = '0;
          pellets_d = PELLET_LD;
          timer_d   = READY_LD;
        end
      end
      S_READY: begin
        if (gs.tick) begin
          timer_d = timer_q - 8'd1;
          if (timer_q == 8'd1) state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        // A pellet in the same clk as a death is still scored.
        if (gs.pellet_eaten) begin
          score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          pellets_d = pellets_q - 9'd1;
        end
        // Clearing the maze beats dying on the same clk.
        if (gs.pellet_eaten && pellets_q == 9'd1) begin
          state_d = S_WON;
        end else if (gs.pacman_is_dead) begin
          state_d = S_DYING;
          timer_d = DEATH_LD;
        end
      end
      S_DYING: begin
        if (gs.tick) begin
          timer_d = timer_q - 8'd1;
          if (timer_q == 8'd1) begin
            lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) begin
              state_d = S_OVER;
            end else begin
              state_d = S_READY;
              timer_d = READY_LD;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; status flags are decoded from the next state so they stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lives_q     <= '0;
      score_q     <= '0;
      pellets_q   <= '0;
      timer_q     <= '0;
      logic_rst_q <= 1'b1;
      freeze_q    <= 1'b1;
      over_q      <= 1'b0;
      won_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      pellets_q   <= pellets_d;
      timer_q     <= timer_d;
      logic_rst_q <= (state_d == S_IDLE) || (state_d == S_READY);
      freeze_q    <= (state_d != S_PLAY);
      over_q      <= (state_d == S_OVER);
      won_q       <= (state_d == S_WON);
    end
  end

  assign gs.state        = state_q;
  assign gs.lives        = lives_q;
  assign gs.score        = score_q;
  assign gs.pellets_left = pellets_q;
  assign gs.logic_rst    = logic_rst_q;
  assign gs.freeze       = freeze_q;
  assign gs.game_over    = over_q;
  assign gs.game_won     = won_q;

endmodule
